tdc_readback_engine: RTL and testbench

Serial read engine for the TDC7200 interface: after a measurement completes, it runs three SPI read frames (TIME1, CALIB1, CALIB2), deserialises the 24-bit responses from MISO and presents them as one result bundle with a valid/ready handshake. It sits between the TDC SPI pins and the range-computation logic. It is the read-side counterpart of the command-byte ROM that configures and triggers the TDC.

---
 rtl/tdc_readback_engine_if.sv | 23 ++
 rtl/tdc_readback_engine.sv | 157 +++++++++++++++
 tb/tb_tdc_readback_engine.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdc_readback_engine_if.sv
// TDC7200 read-side bus: SPI pins plus the result bundle handshake.
// master = engine (drives SPI and results), slave = TDC/consumer side.
interface tdc_readback_engine_if;
    logic        sck;
    logic        csb;
    logic        mosi;
    logic        miso;
    logic [23:0] time1;
    logic [23:0] calib1;
    logic [23:0] calib2;
    logic        res_valid;
    logic        res_ready;

    modport master (
        output sck, csb, mosi, time1, calib1, calib2, res_valid,
        input  miso, res_ready
    );

    modport slave (
        input  sck, csb, mosi, time1, calib1, calib2, res_valid,
        output miso, res_ready
    );
endinterface

// File: rtl/tdc_readback_engine.sv
// Reads TIME1, CALIB1, CALIB2 from the TDC7200 over SPI (mode 0) and
// presents them as one valid/ready bundle.
// Ports: clk, rst_n (async, active low), start, busy, bus (SPI + results).
module tdc_readback_engine #(
    parameter int CLK_DIV = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    tdc_readback_engine_if.master        bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0] GAP_LAST  = 9'(2 * CLK_DIV - 1);

    function automatic logic [7:0] cmd_of(input logic [1:0] f);
        case (f)
            2'd0:    cmd_of = 8'h10;
            2'd1:    cmd_of = 8'h1B;
            default: cmd_of = 8'h1C;
        endcase
    endfunction

    state_t      state, state_next;
    logic [8:0]  cnt;
    logic [4:0]  bit_cnt;
    logic [1:0]  frame;
    logic [7:0]  tx_sr;
    logic [23:0] rx_sr, rx_next;
    logic [23:0] hold0, hold1;
    logic [23:0] time1_q, calib1_q, calib2_q;
    logic        sck_q, csb_q, valid_q;
    logic        phase_end, bit_end, frame_end, gap_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // bit_end is the sck high->low edge: miso sample point and mosi update.
    always_comb begin
        state_next = state;
        phase_end  = 1'b0;
        bit_end    = 1'b0;
        frame_end  = 1'b0;
        gap_end    = 1'b0;
        rx_next    = rx_sr;
        unique case (state)
            IDLE: begin
                if (start) state_next = SHIFT;
            end
            SHIFT: begin
                phase_end = (cnt == HALF_LAST);
                bit_end   = phase_end && sck_q;
                frame_end = bit_end && (bit_cnt == 5'd0);
                if (bit_end && (bit_cnt <= 5'd23))
                    rx_next = {rx_sr[22:0], bus.miso};
                if (frame_end)
                    state_next = (frame == 2'd2) ? DONE : GAP;
            end
            GAP: begin
                gap_end = (cnt == GAP_LAST);
                if (gap_end) state_next = SHIFT;
            end
            DONE: begin
                if (bus.res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            bit_cnt  <= '0;
            frame    <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            hold0    <= '0;
            hold1    <= '0;
            time1_q  <= '0;
            calib1_q <= '0;
            calib2_q <= '0;
            sck_q    <= 1'b0;
            csb_q    <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            rx_sr <= rx_next;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        csb_q   <= 1'b0;
                        sck_q   <= 1'b0;
                        cnt     <= '0;
                        bit_cnt <= 5'd31;
                        frame   <= 2'd0;
                        tx_sr   <= cmd_of(2'd0);
                    end
                end
                SHIFT: begin
                    if (phase_end) begin
                        cnt   <= '0;
                        sck_q <= ~sck_q;
                        if (bit_end) begin
                            bit_cnt <= bit_cnt - 5'd1;
                            // Zero fill: mosi is 0 once the command is out.
                            tx_sr   <= {tx_sr[6:0], 1'b0};
                        end
                        if (frame_end) begin
                            csb_q <= 1'b1;
                            if (frame == 2'd0) begin
                                hold0 <= rx_next;
                            end else if (frame == 2'd1) begin
                                hold1 <= rx_next;
                            end else begin
                                time1_q  <= hold0;
                                calib1_q <= hold1;
                                calib2_q <= rx_next;
                                valid_q  <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        csb_q   <= 1'b0;
                        cnt     <= '0;
                        bit_cnt <= 5'd31;
                        frame   <= frame + 2'd1;
                        tx_sr   <= cmd_of(frame + 2'd1);
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy          = (state != IDLE);
    assign bus.sck       = sck_q;
    assign bus.csb       = csb_q;
    assign bus.mosi      = tx_sr[7];
    assign bus.time1     = time1_q;
    assign bus.calib1    = calib1_q;
    assign bus.calib2    = calib2_q;
    assign bus.res_valid = valid_q;

endmodule

// File: tb/tb_tdc_readback_engine.sv
// Directed bench for tdc_readback_engine: dut_a (CLK_DIV=2) with a TDC
// model on miso, dut_b (CLK_DIV=1) for frame timing.
module tb_tdc_readback_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic busy_a, busy_b;

    always #5 clk = ~clk;

    tdc_readback_engine_if bus_a ();
    tdc_readback_engine_if bus_b ();

    tdc_readback_engine #(.CLK_DIV(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .busy(busy_a), .bus(bus_a)
    );

    tdc_readback_engine #(.CLK_DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .busy(busy_b), .bus(bus_b)
    );

    assign bus_b.miso = 1'b0;

    int passed = 0;
    int total  = 0;

    // TDC model for dut_a: counts sck rises per frame, collects the
    // command byte from mosi and drives response bits on miso.
    logic [23:0] resp [3];
    logic [7:0]  cmd_seen [3];
    logic [7:0]  mosi_sr;
    logic [23:0] word;
    logic        prev_sck, prev_csb;
    logic        model_clr = 1'b1;
    int          fidx, rise;

    always @(negedge clk) begin
        if (model_clr) begin
            fidx = 0;
            rise = 0;
            prev_sck = 1'b0;
            prev_csb = 1'b1;
            mosi_sr = '0;
            for (int i = 0; i < 3; i++) cmd_seen[i] = '0;
            bus_a.miso = 1'b0;
        end else begin
            if (!prev_csb && bus_a.csb) begin
                fidx++;
                rise = 0;
            end
            if (!bus_a.csb && bus_a.sck && !prev_sck) begin
                rise++;
                if (rise <= 8) begin
                    mosi_sr = {mosi_sr[6:0], bus_a.mosi};
                    if (rise == 8 && fidx < 3) cmd_seen[fidx] = mosi_sr;
                end
            end
            if (!bus_a.csb && rise >= 9 && rise <= 32 && fidx < 3) begin
                word = resp[fidx];
                bus_a.miso = word[5'(32 - rise)];
            end else begin
                bus_a.miso = 1'b0;
            end
            prev_sck = bus_a.sck;
            prev_csb = bus_a.csb;
        end
    end

    task automatic clear_model();
        @(posedge clk); #1 model_clr = 1'b1;
        @(posedge clk); #1 model_clr = 1'b0;
    endtask

    // Start pulse; returns just after the edge that samples start.
    task automatic pulse_start_a();
        start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
    endtask

    // Edges after the start edge until res_valid (2000 on timeout).
    task automatic wait_valid_a(output int n);
        n = 0;
        while (bus_a.res_valid !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_a.res_ready = 1'b0;
        bus_b.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus_a.csb !== 1'b1) $display("FAIL rst_low_csb got %b exp 1", bus_a.csb); else passed++;
        total++; if (bus_a.sck !== 1'b0) $display("FAIL rst_low_sck got %b exp 0", bus_a.sck); else passed++;
        total++; if (busy_a !== 1'b0) $display("FAIL rst_low_busy got %b exp 0", busy_a); else passed++;
        rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        total++; if (bus_a.csb !== 1'b1) $display("FAIL reset_csb got %b exp 1", bus_a.csb); else passed++;
        total++; if (bus_a.sck !== 1'b0) $display("FAIL reset_sck got %b exp 0", bus_a.sck); else passed++;
        total++; if (bus_a.mosi !== 1'b0) $display("FAIL reset_mosi got %b exp 0", bus_a.mosi); else passed++;
        total++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy_a); else passed++;
        total++; if (bus_a.res_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus_a.res_valid); else passed++;
        total++; if (bus_a.time1 !== 24'h0) $display("FAIL reset_time1 got %h exp 0", bus_a.time1); else passed++;
        total++; if (bus_a.calib1 !== 24'h0) $display("FAIL reset_calib1 got %h exp 0", bus_a.calib1); else passed++;
        total++; if (bus_a.calib2 !== 24'h0) $display("FAIL reset_calib2 got %h exp 0", bus_a.calib2); else passed++;
        total++; if (bus_b.csb !== 1'b1 || busy_b !== 1'b0) $display("FAIL reset_b got csb=%b busy=%b exp 1/0", bus_b.csb, busy_b); else passed++;
        model_clr = 1'b0;
    endtask

    task automatic test_full_read();
        int n;
        resp[0] = 24'h00ABCD;
        resp[1] = 24'h123456;
        resp[2] = 24'h654321;
        clear_model();
        pulse_start_a();
        total++; if (busy_a !== 1'b1) $display("FAIL full_busy got %b exp 1", busy_a); else passed++;
        total++; if (bus_a.csb !== 1'b0) $display("FAIL full_csb got %b exp 0", bus_a.csb); else passed++;
        total++; if (bus_a.mosi !== 1'b0) $display("FAIL full_mosi0 got %b exp 0", bus_a.mosi); else passed++;
        wait_valid_a(n);
        total++; if (n != 392) $display("FAIL full_latency got %0d exp 392", n); else passed++;
        total++; if (bus_a.csb !== 1'b1) $display("FAIL full_csb_end got %b exp 1", bus_a.csb); else passed++;
        total++; if (bus_a.time1 !== 24'h00ABCD) $display("FAIL full_time1 got %h exp 00abcd", bus_a.time1); else passed++;
        total++; if (bus_a.calib1 !== 24'h123456) $display("FAIL full_calib1 got %h exp 123456", bus_a.calib1); else passed++;
        total++; if (bus_a.calib2 !== 24'h654321) $display("FAIL full_calib2 got %h exp 654321", bus_a.calib2); else passed++;
        total++; if (cmd_seen[0] !== 8'h10) $display("FAIL full_cmd0 got %h exp 10", cmd_seen[0]); else passed++;
        total++; if (cmd_seen[1] !== 8'h1B) $display("FAIL full_cmd1 got %h exp 1b", cmd_seen[1]); else passed++;
        total++; if (cmd_seen[2] !== 8'h1C) $display("FAIL full_cmd2 got %h exp 1c", cmd_seen[2]); else passed++;
        bus_a.res_ready = 1'b1;
        @(posedge clk); #1 bus_a.res_ready = 1'b0;
        total++; if (bus_a.res_valid !== 1'b0) $display("FAIL full_hs_valid got %b exp 0", bus_a.res_valid); else passed++;
        total++; if (busy_a !== 1'b0) $display("FAIL full_hs_busy got %b exp 0", busy_a); else passed++;
        total++; if (bus_a.time1 !== 24'h00ABCD) $display("FAIL full_hold_time1 got %h exp 00abcd", bus_a.time1); else passed++;
    endtask

    task automatic test_frame_timing();
        int low_len [3];
        int rises [3];
        int gap_len [2];
        int f, rv_cyc;
        logic ps, pc;
        for (int i = 0; i < 3; i++) begin
            low_len[i] = 0;
            rises[i] = 0;
        end
        gap_len[0] = 0;
        gap_len[1] = 0;
        f = 0;
        rv_cyc = -1;
        ps = 1'b0;
        pc = 1'b1;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (!bus_b.csb) begin
                if (f < 3) low_len[f]++;
                if (bus_b.sck && !ps && f < 3) rises[f]++;
            end else if (!pc) begin
                f++;
            end
            if (bus_b.csb && f >= 1 && f <= 2) gap_len[f - 1]++;
            ps = bus_b.sck;
            pc = bus_b.csb;
            if (bus_b.res_valid === 1'b1) begin
                rv_cyc = c;
                break;
            end
        end
        for (int i = 0; i < 3; i++) begin
            total++; if (low_len[i] != 64) $display("FAIL timing_csb_low%0d got %0d exp 64", i, low_len[i]); else passed++;
            total++; if (rises[i] != 32) $display("FAIL timing_sck_rises%0d got %0d exp 32", i, rises[i]); else passed++;
        end
        total++; if (gap_len[0] != 2) $display("FAIL timing_gap0 got %0d exp 2", gap_len[0]); else passed++;
        total++; if (gap_len[1] != 2) $display("FAIL timing_gap1 got %0d exp 2", gap_len[1]); else passed++;
        total++; if (rv_cyc != 196) $display("FAIL timing_valid got %0d exp 196", rv_cyc); else passed++;
        bus_b.res_ready = 1'b1;
        @(posedge clk); #1 bus_b.res_ready = 1'b0;
        total++; if (bus_b.res_valid !== 1'b0) $display("FAIL timing_hs got %b exp 0", bus_b.res_valid); else passed++;
    endtask

    task automatic test_backpressure();
        int n;
        logic bad_csb, bad_rv, bad_data, bad_busy;
        resp[0] = 24'h111111;
        resp[1] = 24'h222222;
        resp[2] = 24'h333333;
        clear_model();
        pulse_start_a();
        wait_valid_a(n);
        total++; if (n != 392) $display("FAIL bp_latency got %0d exp 392", n); else passed++;
        bad_csb = 1'b0;
        bad_rv = 1'b0;
        bad_data = 1'b0;
        bad_busy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            start_a = (i % 10 == 3);
            if (bus_a.csb !== 1'b1) bad_csb = 1'b1;
            if (bus_a.res_valid !== 1'b1) bad_rv = 1'b1;
            if (busy_a !== 1'b1) bad_busy = 1'b1;
            if (bus_a.time1 !== 24'h111111 || bus_a.calib1 !== 24'h222222 || bus_a.calib2 !== 24'h333333) bad_data = 1'b1;
        end
        start_a = 1'b0;
        total++; if (bad_csb) $display("FAIL bp_csb got activity exp steady 1"); else passed++;
        total++; if (bad_rv) $display("FAIL bp_valid got drop exp steady 1"); else passed++;
        total++; if (bad_busy) $display("FAIL bp_busy got drop exp steady 1"); else passed++;
        total++; if (bad_data) $display("FAIL bp_data got change exp 111111/222222/333333"); else passed++;
        bus_a.res_ready = 1'b1;
        @(posedge clk); #1 bus_a.res_ready = 1'b0;
        total++; if (bus_a.res_valid !== 1'b0) $display("FAIL bp_hs_valid got %b exp 0", bus_a.res_valid); else passed++;
        @(posedge clk); #1;
        total++; if (busy_a !== 1'b0 || bus_a.csb !== 1'b1) $display("FAIL bp_no_queue got busy=%b csb=%b exp 0/1", busy_a, bus_a.csb); else passed++;
    endtask

    task automatic test_mid_frame_reset();
        int n;
        resp[0] = 24'h0A0B0C;
        resp[1] = 24'h0D0E0F;
        resp[2] = 24'h102030;
        clear_model();
        pulse_start_a();
        n = 0;
        while (!(fidx == 1 && rise == 22) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        total++; if (n >= 2000) $display("FAIL mid_reach got timeout exp frame1 bit10"); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (bus_a.csb !== 1'b1) $display("FAIL mid_csb got %b exp 1", bus_a.csb); else passed++;
        total++; if (bus_a.sck !== 1'b0) $display("FAIL mid_sck got %b exp 0", bus_a.sck); else passed++;
        total++; if (bus_a.res_valid !== 1'b0) $display("FAIL mid_valid got %b exp 0", bus_a.res_valid); else passed++;
        total++; if (busy_a !== 1'b0) $display("FAIL mid_busy got %b exp 0", busy_a); else passed++;
        total++; if (bus_a.time1 !== 24'h0) $display("FAIL mid_time1 got %h exp 0", bus_a.time1); else passed++;
        model_clr = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clr = 1'b0;
        @(posedge clk); #1;
        pulse_start_a();
        wait_valid_a(n);
        total++; if (n != 392) $display("FAIL mid_latency got %0d exp 392", n); else passed++;
        total++; if (bus_a.time1 !== 24'h0A0B0C) $display("FAIL mid_time1_new got %h exp 0a0b0c", bus_a.time1); else passed++;
        total++; if (bus_a.calib1 !== 24'h0D0E0F) $display("FAIL mid_calib1_new got %h exp 0d0e0f", bus_a.calib1); else passed++;
        total++; if (bus_a.calib2 !== 24'h102030) $display("FAIL mid_calib2_new got %h exp 102030", bus_a.calib2); else passed++;
    endtask

    task automatic test_collision();
        bus_a.res_ready = 1'b1;
        start_a = 1'b1;
        @(posedge clk); #1;
        bus_a.res_ready = 1'b0;
        total++; if (bus_a.res_valid !== 1'b0) $display("FAIL coll_valid got %b exp 0", bus_a.res_valid); else passed++;
        total++; if (busy_a !== 1'b0) $display("FAIL coll_busy got %b exp 0", busy_a); else passed++;
        total++; if (bus_a.csb !== 1'b1) $display("FAIL coll_csb got %b exp 1", bus_a.csb); else passed++;
        total++; if (bus_a.time1 !== 24'h0A0B0C) $display("FAIL coll_hold got %h exp 0a0b0c", bus_a.time1); else passed++;
        @(posedge clk); #1 start_a = 1'b0;
        total++; if (busy_a !== 1'b1) $display("FAIL coll_restart_busy got %b exp 1", busy_a); else passed++;
        total++; if (bus_a.csb !== 1'b0) $display("FAIL coll_restart_csb got %b exp 0", bus_a.csb); else passed++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_read();
        test_frame_timing();
        test_backpressure();
        test_mid_frame_reset();
        test_collision();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
